// File: rtl/digit_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_driver_pkg
//  Description : Seven-segment pattern constants shared by the scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package digit_scan_driver_pkg;

   // Segment vector bit order: {a,b,c,d,e,f,g}, bit 6 = a, bit 0 = g.
   typedef struct packed {
      logic a;
      logic b;
      logic c;
      logic d;
      logic e;
      logic f;
      logic g;
   } seg7_bits_t;

   localparam logic [6:0] c_seg_off = 7'h00;
   localparam logic [6:0] c_seg_0   = 7'h7E;
   localparam logic [6:0] c_seg_1   = 7'h30;
   localparam logic [6:0] c_seg_2   = 7'h6D;
   localparam logic [6:0] c_seg_3   = 7'h79;
   localparam logic [6:0] c_seg_4   = 7'h33;
   localparam logic [6:0] c_seg_5   = 7'h5B;
   localparam logic [6:0] c_seg_6   = 7'h5F;
   localparam logic [6:0] c_seg_7   = 7'h70;
   localparam logic [6:0] c_seg_8   = 7'h7F;
   localparam logic [6:0] c_seg_9   = 7'h7B;
   localparam logic [6:0] c_seg_a   = 7'h77;
   localparam logic [6:0] c_seg_b   = 7'h1F;
   localparam logic [6:0] c_seg_c   = 7'h4E;
   localparam logic [6:0] c_seg_d   = 7'h3D;
   localparam logic [6:0] c_seg_e   = 7'h4F;
   localparam logic [6:0] c_seg_f   = 7'h47;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decoder
//  Description : Combinational 4-bit hex code to seven-segment pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
   import digit_scan_driver_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = c_seg_off;
      case (i_code)
         4'h0: o_seg = c_seg_0;
         4'h1: o_seg = c_seg_1;
         4'h2: o_seg = c_seg_2;
         4'h3: o_seg = c_seg_3;
         4'h4: o_seg = c_seg_4;
         4'h5: o_seg = c_seg_5;
         4'h6: o_seg = c_seg_6;
         4'h7: o_seg = c_seg_7;
         4'h8: o_seg = c_seg_8;
         4'h9: o_seg = c_seg_9;
         4'hA: o_seg = c_seg_a;
         4'hB: o_seg = c_seg_b;
         4'hC: o_seg = c_seg_c;
         4'hD: o_seg = c_seg_d;
         4'hE: o_seg = c_seg_e;
         4'hF: o_seg = c_seg_f;
         default: o_seg = c_seg_off;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/digit_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_driver
//  Description : N-digit multiplexed seven-segment scanner with dead time,
//                leading-zero suppression and per-frame input snapshots.
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_driver
   import digit_scan_driver_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                en_i,
   input  logic [4*DIGITS-1:0] bcd_i,
   input  logic [DIGITS-1:0]   dp_i,
   input  logic [DIGITS-1:0]   blank_i,
   input  logic                lz_en_i,
   output logic [DIGITS-1:0]   sel_o,
   output logic [6:0]          seg_o,
   output logic                dp_o,
   output logic                frame_o
);

   localparam int c_cnt_w  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int c_slot_w = (DIGITS > 2) ? $clog2(DIGITS) : 1;
   localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(CLK_DIV - 1);
   localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(DIGITS - 1);

   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_slot_w-1:0] r_slot;
   logic [4*DIGITS-1:0] r_snap_bcd;
   logic [DIGITS-1:0]   r_snap_dp;
   logic [DIGITS-1:0]   r_snap_blank;
   logic                r_snap_lz;
   logic [DIGITS-1:0]   r_sel;
   logic [6:0]          r_seg;
   logic                r_dp;
   logic                r_frame;

   logic                w_slot_end;
   logic                w_boundary;
   logic                w_snap_load;
   logic [DIGITS-1:0]   w_supp;
   logic                w_zero_run;
   logic [3:0]          w_code;
   logic                w_dp_sel;
   logic                w_dark_sel;
   logic                w_active;
   logic [DIGITS-1:0]   w_sel_nxt;
   logic [6:0]          w_seg_dec;

   assign w_slot_end  = (r_cnt == c_cnt_last);
   assign w_boundary  = en_i && w_slot_end && (r_slot == c_slot_last);
   assign w_snap_load = w_boundary || !en_i;

   // A digit is a leading zero when it and every more significant digit are 0.
   always_comb begin
      w_supp     = '0;
      w_zero_run = r_snap_lz;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_zero_run = w_zero_run && (r_snap_bcd[4*k +: 4] == 4'd0);
         w_supp[k]  = w_zero_run;
      end
   end

   always_comb begin
      w_code     = 4'd0;
      w_dp_sel   = 1'b0;
      w_dark_sel = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_slot == c_slot_w'(k)) begin
            w_code     = r_snap_bcd[4*k +: 4];
            w_dp_sel   = r_snap_dp[k];
            w_dark_sel = r_snap_blank[k] | w_supp[k];
         end
      end
      w_active  = en_i && (int'(r_cnt) >= BLANK_CYCLES) && !w_dark_sel;
      w_sel_nxt = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_active && (r_slot == c_slot_w'(k))) begin
            w_sel_nxt[k] = 1'b0;
         end
      end
   end

   seg7_hex_decoder u_decoder (
      .i_code (w_code),
      .o_seg  (w_seg_dec)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt        <= '0;
         r_slot       <= '0;
         r_snap_bcd   <= '0;
         r_snap_dp    <= '0;
         r_snap_blank <= '0;
         r_snap_lz    <= 1'b0;
         r_sel        <= '1;
         r_seg        <= c_seg_off;
         r_dp         <= 1'b0;
         r_frame      <= 1'b0;
      end else begin
         if (!en_i) begin
            r_cnt  <= '0;
            r_slot <= '0;
         end else if (w_slot_end) begin
            r_cnt  <= '0;
            r_slot <= (r_slot == c_slot_last) ? '0 : r_slot + c_slot_w'(1);
         end else begin
            r_cnt  <= r_cnt + c_cnt_w'(1);
         end

         if (w_snap_load) begin
            r_snap_bcd   <= bcd_i;
            r_snap_dp    <= dp_i;
            r_snap_blank <= blank_i;
            r_snap_lz    <= lz_en_i;
         end

         r_frame <= w_boundary;
         r_sel   <= w_sel_nxt;
         r_seg   <= w_active ? w_seg_dec : c_seg_off;
         r_dp    <= w_active & w_dp_sel;
      end
   end

   assign sel_o   = r_sel;
   assign seg_o   = r_seg;
   assign dp_o    = r_dp;
   assign frame_o = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan_driver
//  Description : Self-checking bench for digit_scan_driver (4 digits, div 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_driver;

   localparam int DIGITS       = 4;
   localparam int CLK_DIV      = 8;
   localparam int BLANK_CYCLES = 2;
   localparam int FRAME        = DIGITS * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] bcd;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        lz_en;
   logic [3:0]  sel;
   logic [6:0]  seg;
   logic        dp_out;
   logic        frame;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   digit_scan_driver #(
      .DIGITS       (DIGITS),
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .en_i    (en),
      .bcd_i   (bcd),
      .dp_i    (dp),
      .blank_i (blank),
      .lz_en_i (lz_en),
      .sel_o   (sel),
      .seg_o   (seg),
      .dp_o    (dp_out),
      .frame_o (frame)
   );

   // Reference model: position within the frame plus the frame's snapshot.
   logic [6:0]  seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
   int          m_pos;
   logic [15:0] m_bcd;
   logic [3:0]  m_dp;
   logic [3:0]  m_blank;
   logic        m_lz;
   logic [3:0]  e_sel;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_frame;

   task automatic model_reset();
      m_pos   = 0;
      m_bcd   = '0;
      m_dp    = '0;
      m_blank = '0;
      m_lz    = 1'b0;
      e_sel   = 4'hF;
      e_seg   = 7'h00;
      e_dp    = 1'b0;
      e_frame = 1'b0;
   endtask

   task automatic model_edge();
      int   slot;
      int   c;
      int   digit;
      bit   supp;
      bit   lit;
      logic [15:0] upper;
      if (!en) begin
         e_sel = 4'hF; e_seg = 7'h00; e_dp = 1'b0; e_frame = 1'b0;
         m_pos = 0;
         m_bcd = bcd; m_dp = dp; m_blank = blank; m_lz = lz_en;
         return;
      end
      slot  = (m_pos / CLK_DIV) % DIGITS;
      c     = m_pos % CLK_DIV;
      upper = m_bcd >> (4 * slot);
      digit = int'(upper & 16'h000F);
      supp  = m_lz && (slot > 0) && (upper == 16'h0000);
      lit   = (c >= BLANK_CYCLES) && !m_blank[slot] && !supp;
      e_sel   = lit ? ~(4'b0001 << slot) : 4'hF;
      e_seg   = lit ? seg_tab[digit] : 7'h00;
      e_dp    = lit && m_dp[slot];
      e_frame = (m_pos == FRAME - 1);
      if (e_frame) begin
         m_bcd = bcd; m_dp = dp; m_blank = blank; m_lz = lz_en;
      end
      m_pos = (m_pos + 1) % FRAME;
   endtask

   // One clock: model advances on the edge, outputs are then read on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      bit seen;
      int n;
      en = 1'b1; bcd = 16'h1234; dp = 4'b0000; blank = 4'b0000; lz_en = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cycle();
         seen = (sel != 4'hF);
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL reset_prelit: sel stayed %b, required a lit digit", sel);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({sel, seg, dp_out, frame} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_async: got sel=%b seg=%h dp=%b fr=%b, required 1111/00/0/0",
                  sel, seg, dp_out, frame);
      end
      model_reset();
      #1 rst_n = 1'b1;
      n = 0;
      seen = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         cycle();
         n_tests++;
         if ({sel, seg, dp_out, frame} !== {e_sel, e_seg, e_dp, e_frame}) begin
            n_fail++;
            $display("FAIL reset_model t=%0t: got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                     sel, seg, dp_out, frame, e_sel, e_seg, e_dp, e_frame);
         end
         if (sel != 4'hF) begin
            seen = 1;
            n    = i;
         end
      end
      n_tests++;
      if (!(seen && n == 3 && sel == 4'b1110 && seg == 7'h7E)) begin
         n_fail++;
         $display("FAIL reset_first_lit: got cycle %0d sel=%b seg=%h, required cycle 3 1110/7E",
                  n, sel, seg);
      end
   endtask

   task automatic test_scan_order();
      bit         found;
      int         slot;
      int         c;
      logic [3:0] xs;
      logic [6:0] xg;
      logic       xd;
      logic [6:0] segs [4] = '{7'h33, 7'h79, 7'h6D, 7'h30};
      logic       dps  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      bcd = 16'h1234; dp = 4'b0010; blank = 4'b0000; lz_en = 1'b0; en = 1'b1;
      found = 0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         cycle();
         found = frame;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL scan_frame_wait: frame_o never pulsed, required a pulse");
      end
      for (int i = 0; i < FRAME; i++) begin
         cycle();
         n_tests++;
         if ({sel, seg, dp_out, frame} !== {e_sel, e_seg, e_dp, e_frame}) begin
            n_fail++;
            $display("FAIL scan_model t=%0t: got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                     sel, seg, dp_out, frame, e_sel, e_seg, e_dp, e_frame);
         end
         slot = i / CLK_DIV;
         c    = i % CLK_DIV;
         xs   = (c >= BLANK_CYCLES) ? ~(4'b0001 << slot) : 4'hF;
         xg   = (c >= BLANK_CYCLES) ? segs[slot] : 7'h00;
         xd   = (c >= BLANK_CYCLES) ? dps[slot] : 1'b0;
         n_tests++;
         if ({sel, seg, dp_out, frame} !== {xs, xg, xd, (i == FRAME - 1)}) begin
            n_fail++;
            $display("FAIL scan_order slot %0d cnt %0d: got %b/%h/%b/%b want %b/%h/%b/%b",
                     slot, c, sel, seg, dp_out, frame, xs, xg, xd, (i == FRAME - 1));
         end
      end
   endtask

   task automatic test_lead_zero();
      logic [15:0] c_bcd  [3] = '{16'h0050, 16'h0000, 16'h0000};
      logic        c_lz   [3] = '{1'b1, 1'b1, 1'b0};
      logic [3:0]  c_mask [3] = '{4'b0011, 4'b0001, 4'b1111};
      logic [3:0]  seen_mask;
      logic [3:0]  onehot;
      logic [6:0]  xg;
      bit          found;
      dp = 4'b0000; blank = 4'b0000; en = 1'b1;
      for (int t = 0; t < 3; t++) begin
         bcd = c_bcd[t]; lz_en = c_lz[t];
         found = 0;
         for (int i = 0; i < 2 * FRAME && !found; i++) begin
            cycle();
            found = frame;
         end
         n_tests++;
         if (!found) begin
            n_fail++;
            $display("FAIL lz_frame_wait case %0d: frame_o never pulsed", t);
         end
         seen_mask = 4'b0000;
         for (int i = 0; i < FRAME; i++) begin
            cycle();
            n_tests++;
            if ({sel, seg, dp_out, frame} !== {e_sel, e_seg, e_dp, e_frame}) begin
               n_fail++;
               $display("FAIL lz_model case %0d t=%0t: got %b/%h/%b/%b want %b/%h/%b/%b", t,
                        $time, sel, seg, dp_out, frame, e_sel, e_seg, e_dp, e_frame);
            end
            seen_mask |= ~sel;
            for (int k = 0; k < DIGITS; k++) begin
               onehot = ~(4'b0001 << k);
               xg     = (t == 0 && k == 1) ? 7'h5B : 7'h7E;
               if (sel == onehot) begin
                  n_tests++;
                  if (seg !== xg) begin
                     n_fail++;
                     $display("FAIL lz_seg case %0d digit %0d: got %h want %h", t, k, seg, xg);
                  end
               end
            end
         end
         n_tests++;
         if (seen_mask !== c_mask[t]) begin
            n_fail++;
            $display("FAIL lz_digits case %0d: lit digits %b, required %b", t, seen_mask, c_mask[t]);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [6:0] old_segs [4] = '{7'h33, 7'h79, 7'h6D, 7'h30};
      logic [6:0] new_segs [4] = '{7'h3D, 7'h4E, 7'h1F, 7'h77};
      logic [6:0] xg;
      bit         found;
      int         slot;
      bcd = 16'h1234; dp = 4'b0000; blank = 4'b0000; lz_en = 1'b0; en = 1'b1;
      found = 0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         cycle();
         found = frame;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL snap_frame_wait: frame_o never pulsed");
      end
      for (int i = 0; i < 2 * FRAME; i++) begin
         cycle();
         if (i == 10) bcd = 16'hABCD;
         n_tests++;
         if ({sel, seg, dp_out, frame} !== {e_sel, e_seg, e_dp, e_frame}) begin
            n_fail++;
            $display("FAIL snap_model t=%0t: got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                     sel, seg, dp_out, frame, e_sel, e_seg, e_dp, e_frame);
         end
         slot = (i % FRAME) / CLK_DIV;
         if (sel != 4'hF) begin
            xg = (i < FRAME) ? old_segs[slot] : new_segs[slot];
            n_tests++;
            if (seg !== xg) begin
               n_fail++;
               $display("FAIL snap_seg frame %0d slot %0d: got %h want %h", i / FRAME, slot, seg, xg);
            end
         end
      end
   endtask

   task automatic test_blank_enable();
      logic [3:0] seen_mask;
      bit         found;
      bit         seen;
      int         n;
      bcd = 16'h1234; dp = 4'b0000; blank = 4'b0100; lz_en = 1'b0; en = 1'b1;
      found = 0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         cycle();
         found = frame;
      end
      seen_mask = 4'b0000;
      for (int i = 0; i < FRAME; i++) begin
         cycle();
         n_tests++;
         if ({sel, seg, dp_out, frame} !== {e_sel, e_seg, e_dp, e_frame}) begin
            n_fail++;
            $display("FAIL blank_model t=%0t: got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                     sel, seg, dp_out, frame, e_sel, e_seg, e_dp, e_frame);
         end
         seen_mask |= ~sel;
      end
      n_tests++;
      if (!found || seen_mask !== 4'b1011) begin
         n_fail++;
         $display("FAIL blank_digits: lit digits %b (frame seen %0d), required 1011", seen_mask, found);
      end
      // Disable in the middle of slot 2 with every digit visible.
      blank = 4'b0000;
      found = 0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         cycle();
         found = frame;
      end
      for (int i = 0; i <= 2 * CLK_DIV + 2; i++) cycle();
      n_tests++;
      if (!found || sel !== 4'b1011) begin
         n_fail++;
         $display("FAIL en_pre_lit: got sel=%b, required 1011 before disable", sel);
      end
      en = 1'b0;
      cycle();
      n_tests++;
      if ({sel, seg, dp_out, frame} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL en_off_dark: got %b/%h/%b/%b, required 1111/00/0/0", sel, seg, dp_out, frame);
      end
      repeat (5) cycle();
      en = 1'b1;
      seen = 0;
      n = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         cycle();
         n_tests++;
         if ({sel, seg, dp_out, frame} !== {e_sel, e_seg, e_dp, e_frame}) begin
            n_fail++;
            $display("FAIL en_model t=%0t: got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                     sel, seg, dp_out, frame, e_sel, e_seg, e_dp, e_frame);
         end
         if (sel != 4'hF) begin
            seen = 1;
            n    = i;
         end
      end
      n_tests++;
      if (!(seen && n == 3 && sel == 4'b1110 && seg == 7'h33)) begin
         n_fail++;
         $display("FAIL en_restart: got cycle %0d sel=%b seg=%h, required cycle 3 1110/33", n, sel, seg);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(15) == 0) begin
            bcd   = 16'($urandom);
            dp    = 4'($urandom);
            blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
            lz_en = 1'($urandom);
         end
         if ($urandom_range(149) == 0) en = ~en;
         if (!en && $urandom_range(9) == 0) en = 1'b1;
         cycle();
         n_tests++;
         if ({sel, seg, dp_out, frame} !== {e_sel, e_seg, e_dp, e_frame}) begin
            n_fail++;
            $display("FAIL random_model t=%0t: got %b/%h/%b/%b want %b/%h/%b/%b", $time,
                     sel, seg, dp_out, frame, e_sel, e_seg, e_dp, e_frame);
         end
         n_tests++;
         if ($countones(~sel) > 1) begin
            n_fail++;
            $display("FAIL random_onehot t=%0t: got sel=%b, required at most one low", $time, sel);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; bcd = 16'h0000; dp = 4'b0000; blank = 4'b0000; lz_en = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_scan_order();
      test_lead_zero();
      test_snapshot();
      test_blank_enable();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
